// File: rtl/range_drain_if.sv
// Host-side bundle for range_drain: seed command channel, result beat stream,
// end-of-run summary and timeout flag.
interface range_drain_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_start;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_n;
    logic [15:0] out_count;
    logic        out_last;

    logic        sum_valid;
    logic [15:0] sum_max_count;
    logic [31:0] sum_max_n;

    logic        err_timeout;

    modport master (
        output cmd_valid,
        output cmd_start,
        output out_ready,
        input  cmd_ready,
        input  out_valid,
        input  out_n,
        input  out_count,
        input  out_last,
        input  sum_valid,
        input  sum_max_count,
        input  sum_max_n,
        input  err_timeout
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  out_ready,
        output cmd_ready,
        output out_valid,
        output out_n,
        output out_count,
        output out_last,
        output sum_valid,
        output sum_max_count,
        output sum_max_n,
        output err_timeout
    );
endinterface

// File: rtl/range_drain.sv
// Command sequencer and result drain for the range engine: launches a run,
// reads every RAM entry back and streams (n, count) beats plus a max summary.
module range_drain #(
    parameter int RAM_WORDS      = 16,
    parameter int RAM_ADDR_BITS  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    range_drain_if.slave host,
    output logic        rng_go,
    output logic [31:0] rng_start,
    input  logic        rng_done,
    input  logic [15:0] rng_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]            TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX     = RAM_ADDR_BITS'(RAM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        ADDR,
        CAPT,
        OUT,
        SUM
    } state_t;

    state_t                   state_q, state_d;
    logic [31:0]              base_q, base_d;
    logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [31:0]              out_n_q, out_n_d;
    logic [15:0]              out_count_q, out_count_d;
    logic                     out_last_q, out_last_d;
    logic [15:0]              max_count_q, max_count_d;
    logic [31:0]              max_n_q, max_n_d;
    logic [31:0]              cur_n;

    assign cur_n = base_q + 32'(idx_q);

    // The timeout counter runs from LAUNCH onward, so the abort lands
    // TIMEOUT_CYCLES-1 cycles after the go pulse.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        idx_d            = idx_q;
        tmo_d            = '0;
        out_n_d          = out_n_q;
        out_count_d      = out_count_q;
        out_last_d       = out_last_q;
        max_count_d      = max_count_q;
        max_n_d          = max_n_q;
        host.cmd_ready   = 1'b0;
        host.out_valid   = 1'b0;
        host.sum_valid   = 1'b0;
        host.err_timeout = 1'b0;
        rng_go           = 1'b0;
        rng_start        = '0;

        case (state_q)
            IDLE: begin
                host.cmd_ready = 1'b1;
                if (host.cmd_valid) begin
                    base_d  = host.cmd_start;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                rng_go      = 1'b1;
                rng_start   = base_q;
                max_count_d = '0;
                max_n_d     = '0;
                idx_d       = '0;
                tmo_d       = tmo_q + 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                rng_start = base_q;
                if (rng_done) begin
                    state_d = ADDR;
                end else if (tmo_q == TIMEOUT_LAST) begin
                    host.err_timeout = 1'b1;
                    state_d          = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ADDR: begin
                rng_start = 32'(idx_q);
                state_d   = CAPT;
            end
            CAPT: begin
                rng_start   = 32'(idx_q);
                out_count_d = rng_count;
                out_n_d     = cur_n;
                out_last_d  = (idx_q == LAST_IDX);
                // Strict compare keeps the lowest index on ties.
                if (rng_count > max_count_q) begin
                    max_count_d = rng_count;
                    max_n_d     = cur_n;
                end
                state_d = OUT;
            end
            OUT: begin
                rng_start      = 32'(idx_q);
                host.out_valid = 1'b1;
                if (host.out_ready) begin
                    if (out_last_q) begin
                        state_d = SUM;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ADDR;
                    end
                end
            end
            SUM: begin
                host.sum_valid = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            out_n_q     <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
            max_count_q <= '0;
            max_n_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            out_n_q     <= out_n_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
            max_count_q <= max_count_d;
            max_n_q     <= max_n_d;
        end
    end

    assign host.out_n         = out_n_q;
    assign host.out_count     = out_count_q;
    assign host.out_last      = out_last_q;
    assign host.sum_max_count = max_count_q;
    assign host.sum_max_n     = max_n_q;
endmodule

// File: tb/tb_range_drain.sv
// Scoreboard bench for range_drain with a behavioural range stub
// (done 40 cycles after go, registered read of a mode-selected memory).
`timescale 1ns/1ps
module tb_range_drain;
    localparam int RAM_WORDS  = 16;
    localparam int TMO        = 64;
    localparam int DONE_DELAY = 40;

    typedef struct {
        logic [31:0] n;
        logic [15:0] count;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] max_count;
        logic [31:0] max_n;
    } sum_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rng_go;
    logic [31:0] rng_start;
    logic        rng_done;
    logic [15:0] rng_count;
    logic        stray_done;

    int stub_mode;
    int ready_mode;
    int go_timer;
    int cycle = 0;
    int launch_cycle;
    int beats_done;
    int tests_run;
    int tests_failed;
    sum_t last_sum;

    beat_t exp_beats[$];
    sum_t  exp_sums[$];
    int    exp_tmo[$];

    range_drain_if bus();

    range_drain #(
        .RAM_WORDS(RAM_WORDS),
        .RAM_ADDR_BITS(4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .host(bus),
        .rng_go(rng_go),
        .rng_start(rng_start),
        .rng_done(rng_done),
        .rng_count(rng_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Stub memory: mode 0 -> 3*i+1, mode 1 -> all 7, mode 2 -> 3*i+1 but done never fires.
    function automatic logic [15:0] mem_val(input int mode, input int idx);
        if (mode == 1) return 16'd7;
        return 16'(3 * idx + 1);
    endfunction

    always @(posedge clk) begin
        if (reset) go_timer <= 0;
        else if (rng_go) go_timer <= DONE_DELAY;
        else if (go_timer != 0) go_timer <= go_timer - 1;
        rng_count <= mem_val(stub_mode, int'(rng_start[3:0]));
    end

    assign rng_done = ((go_timer == 1) && (stub_mode != 2)) || stray_done;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Mode 1 of ready_mode accepts one beat in three.
    initial begin
        int phase;
        phase = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            phase++;
            bus.out_ready = (ready_mode == 0) || (phase % 3 == 0);
        end
    end

    task automatic applyStimulus(input logic [31:0] base, input int mode, input int rmode);
        logic [15:0] mx_c;
        logic [31:0] mx_n;
        beat_t       b;
        sum_t        s;
        int          budget;
        stub_mode  = mode;
        ready_mode = rmode;
        if (mode == 2) begin
            exp_tmo.push_back(TMO - 1);
        end else begin
            mx_c = '0;
            mx_n = '0;
            for (int i = 0; i < RAM_WORDS; i++) begin
                b.n     = base + 32'(i);
                b.count = mem_val(mode, i);
                b.last  = (i == RAM_WORDS - 1);
                exp_beats.push_back(b);
                if (b.count > mx_c) begin
                    mx_c = b.count;
                    mx_n = b.n;
                end
            end
            s.max_count = mx_c;
            s.max_n     = mx_n;
            exp_sums.push_back(s);
            last_sum = s;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_start = base;
        budget = 0;
        while (!bus.cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_start = '0;
        launch_cycle  = cycle;
        checkOutput("go_pulse", 32'(rng_go), 32'd1);
        checkOutput("go_start", rng_start, base);
        @(negedge clk);
        checkOutput("go_single", 32'(rng_go), 32'd0);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((exp_beats.size() + exp_sums.size() + exp_tmo.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", 32'(exp_beats.size() + exp_sums.size() + exp_tmo.size()), 32'd0);
        exp_beats.delete();
        exp_sums.delete();
        exp_tmo.delete();
        @(negedge clk);
        checkOutput("idle_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat, summary or error.
    initial begin
        beat_t       b;
        sum_t        s;
        logic        held;
        logic [31:0] h_n;
        logic [15:0] h_c;
        logic        h_l;
        logic        prev_err;
        held     = 1'b0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                held     = 1'b0;
                prev_err = 1'b0;
            end else begin
                if (held && bus.out_valid) begin
                    checkOutput("stall_n", bus.out_n, h_n);
                    checkOutput("stall_count", 32'(bus.out_count), 32'(h_c));
                    checkOutput("stall_last", 32'(bus.out_last), 32'(h_l));
                end
                held = 1'b0;
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        if (exp_beats.size() == 0) begin
                            checkOutput("unexpected_beat", 32'(bus.out_valid), 32'd0);
                        end else begin
                            b = exp_beats.pop_front();
                            checkOutput("beat_n", bus.out_n, b.n);
                            checkOutput("beat_count", 32'(bus.out_count), 32'(b.count));
                            checkOutput("beat_last", 32'(bus.out_last), 32'(b.last));
                            beats_done++;
                        end
                    end else begin
                        held = 1'b1;
                        h_n  = bus.out_n;
                        h_c  = bus.out_count;
                        h_l  = bus.out_last;
                    end
                end
                if (bus.sum_valid) begin
                    if (exp_sums.size() == 0) begin
                        checkOutput("unexpected_sum", 32'(bus.sum_valid), 32'd0);
                    end else begin
                        s = exp_sums.pop_front();
                        checkOutput("sum_max_count", 32'(bus.sum_max_count), 32'(s.max_count));
                        checkOutput("sum_max_n", bus.sum_max_n, s.max_n);
                    end
                end
                if (bus.err_timeout) begin
                    checkOutput("err_single", 32'(prev_err), 32'd0);
                    if (exp_tmo.size() == 0) begin
                        checkOutput("unexpected_err", 32'(bus.err_timeout), 32'd0);
                    end else begin
                        checkOutput("err_latency", 32'(cycle - launch_cycle), 32'(exp_tmo.pop_front()));
                    end
                end
                prev_err = bus.err_timeout;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b0;
        int budget;
        tests_run     = 0;
        tests_failed  = 0;
        beats_done    = 0;
        stub_mode     = 0;
        ready_mode    = 0;
        stray_done    = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_start = '0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
        checkOutput("rst_err", 32'(bus.err_timeout), 32'd0);
        checkOutput("rst_go", 32'(rng_go), 32'd0);
        checkOutput("rst_out_n", bus.out_n, 32'd0);
        checkOutput("rst_sum_max_n", bus.sum_max_n, 32'd0);

        // Basic run, always ready.
        applyStimulus(32'd100, 0, 0);
        waitDrain(1000);
        checkOutput("sum_hold_count", 32'(bus.sum_max_count), 32'(last_sum.max_count));
        checkOutput("sum_hold_n", bus.sum_max_n, last_sum.max_n);

        // Same run with back-pressure.
        applyStimulus(32'd100, 0, 1);
        waitDrain(2000);

        // All counts equal: first index wins.
        applyStimulus(32'd500, 1, 0);
        waitDrain(1000);

        // No done: timeout abort.
        applyStimulus(32'h0000_1234, 2, 0);
        waitDrain(200);
        checkOutput("tmo_no_beats", 32'(bus.out_valid), 32'd0);

        // Wrap-around of n.
        applyStimulus(32'hFFFF_FFFE, 0, 0);
        waitDrain(1000);

        // Reset while beat 5 is presented.
        b0 = beats_done;
        applyStimulus(32'd300, 0, 0);
        budget = 0;
        while (!((beats_done - b0) == 5 && bus.out_valid) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("reach_beat5", 32'(beats_done - b0), 32'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_beats.delete();
        exp_sums.delete();
        exp_tmo.delete();
        checkOutput("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_out_n", bus.out_n, 32'd0);
        checkOutput("mid_rst_out_count", 32'(bus.out_count), 32'd0);
        checkOutput("mid_rst_sum_max", 32'(bus.sum_max_count), 32'd0);
        checkOutput("mid_rst_rng_start", rng_start, 32'd0);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stray_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("stray_out_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(32'd7, 0, 0);
        waitDrain(1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
